pc_seq_ctrl: RTL and testbench
==============================

Name: pc_seq_ctrl

Overview:
Sequencer for the program-counter register. It arbitrates per cycle between:
- branch/PC-write redirects from execute;
- synchronous exceptions (dabt, pabt, und, swi);
- asynchronous IRQ/FIQ.

It drives the PC register's enable, write-enable and write value, then flushes the pipeline for a fixed refill period. It also reports the exception entry mode and return address to the register-bank/CPSR logic.

Parameters:
FLUSH_CYCLES, 2, cycles o_flush stays high after the redirect cycle (pipeline refill); legal range 1..7
SYNC_STAGES, 2, flop stages on i_irq/i_fiq before use; legal range 2..3

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
i_stall  in  1  downstream stall; PC must not advance
i_pc  in  32  current PC value from the PC register
i_br_valid  in  1  branch/PC-write request from execute
i_br_target  in  32  branch target
i_dabt  in  1  data abort on the executing instruction
i_pabt  in  1  prefetch abort on the executing instruction
i_und  in  1  undefined instruction
i_swi  in  1  software interrupt
i_irq  in  1  asynchronous IRQ level
i_fiq  in  1  asynchronous FIQ level
i_irq_mask  in  1  CPSR I bit
i_fiq_mask  in  1  CPSR F bit
o_pc_en  out  1  PC register clock enable
o_pc_wr_en  out  1  load PC from o_pc_wr_val instead of PC+4
o_pc_wr_val  out  32  redirect value
o_flush  out  1  kill fetched/decoded instructions
o_exc_valid  out  1  one-cycle pulse: exception entry committed
o_exc_mode  out  5  ARM mode for the entry
o_exc_lr  out  32  return address (i_pc captured at the event)
o_busy  out  1  state != RUN

Behaviour:
- States: RUN, REDIRECT, REFILL. Reset enters RUN.
- Reset values:
  - o_pc_wr_en=0, o_pc_wr_val=0, o_flush=0, o_exc_valid=0.
  - o_exc_mode=5'b10011, o_exc_lr=0, o_busy=0.
  - Refill counter=0; sync flops=0.
- o_pc_en:
  - RUN: o_pc_en = !i_stall.
  - REDIRECT: o_pc_en = !i_stall.
  - REFILL: o_pc_en = 1 (i_stall is ignored; the pipeline is empty).
- IRQ/FIQ are sampled through SYNC_STAGES flops: irq_s, fiq_s.
  - An interrupt is pending when irq_s && !i_irq_mask, or fiq_s && !i_fiq_mask.
- RUN with i_stall=1: all requests are ignored; no state change.
- RUN with i_stall=0: the highest-priority active request is accepted.
  - Priority: dabt > fiq > irq > pabt > und > swi > branch.
  - Vectors and modes:
    - dabt: 0x10, 10111
    - fiq: 0x1C, 10001
    - irq: 0x18, 10010
    - pabt: 0x0C, 10111
    - und: 0x04, 11011
    - swi: 0x08, 10011
    - branch: i_br_target, mode unchanged
  - Registered on the accept edge: o_pc_wr_val = vector/target, o_exc_lr = i_pc, o_exc_mode.
  - Next state REDIRECT.
  - A branch in the same cycle as any exception/interrupt is discarded.
  - Lower-priority synchronous requests are dropped; execute re-raises them if still valid.
- REDIRECT:
  - o_pc_wr_en=1, o_flush=1.
  - o_exc_valid=1 only on the first REDIRECT cycle, and only for exception/interrupt (not branch).
  - If i_stall=1: stay in REDIRECT; PC holds; o_pc_wr_val stable; o_exc_valid not repeated.
  - If i_stall=0: PC loads o_pc_wr_val at the edge; go to REFILL; counter=FLUSH_CYCLES-1.
- REFILL:
  - o_flush=1, o_pc_wr_en=0.
  - Counter decrements each cycle; at 0 go to RUN.
  - All requests are ignored. Pending IRQ/FIQ levels remain and are taken in RUN if still unmasked.
- Redirect latency: request in cycle N → o_pc_wr_en in N+1.
  - With no stall, the PC equals the target after the N+1 edge.
  - Back in RUN after N+1+FLUSH_CYCLES.
- Asserting rst in any state aborts the sequence immediately. All outputs take reset values asynchronously.
- o_pc_wr_val is full 32-bit; no wrap checks. A target of 0xFFFFFFFC is loaded as-is.

Test Plan:
- Reset release, no requests, i_stall=0 → o_pc_en=1, o_pc_wr_en=0, o_busy=0, PC increments by 4 each cycle.
- i_br_valid=1 with target 0x0000_0100 at cycle N, FLUSH_CYCLES=2:
  - N+1: o_pc_wr_en=1, o_pc_wr_val=0x100, o_exc_valid=0.
  - o_flush high for N+1..N+3; RUN at N+4.
- i_dabt=1, i_br_valid=1, i_irq held unmasked, i_pc=0x2000 in the same cycle → o_pc_wr_val=0x10, o_exc_mode=10111, o_exc_lr=0x2000, single o_exc_valid pulse.
- i_irq asserted with i_irq_mask=0:
  - Taken 2 cycles later (SYNC_STAGES=2) with vector 0x18, mode 10010.
  - Same stimulus with i_irq_mask=1 → no redirect.
- SWI accepted, then i_stall=1 for 3 cycles during REDIRECT → o_pc_en=0, o_pc_wr_en held, o_exc_valid pulses once; on stall release PC=0x08.
- rst asserted mid-REFILL → outputs go to reset values asynchronously; FSM in RUN after release; no residual flush.

Source files
------------

// File: rtl/pc_seq_ctrl.sv
// PC sequencer: arbitrates branches, synchronous exceptions and IRQ/FIQ into a PC redirect,
// then flushes the pipeline for FLUSH_CYCLES refill cycles; reports the exception entry mode and LR.
module pc_seq_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    input  logic [31:0] i_pc,
    input  logic        i_br_valid,
    input  logic [31:0] i_br_target,
    input  logic        i_dabt,
    input  logic        i_pabt,
    input  logic        i_und,
    input  logic        i_swi,
    input  logic        i_irq,
    input  logic        i_fiq,
    input  logic        i_irq_mask,
    input  logic        i_fiq_mask,
    output logic        o_pc_en,
    output logic        o_pc_wr_en,
    output logic [31:0] o_pc_wr_val,
    output logic        o_flush,
    output logic        o_exc_valid,
    output logic [4:0]  o_exc_mode,
    output logic [31:0] o_exc_lr,
    output logic        o_busy
);
    typedef enum logic [1:0] {ST_RUN, ST_REDIRECT, ST_REFILL} state_t;

    localparam logic [4:0] MODE_FIQ = 5'b10001;
    localparam logic [4:0] MODE_IRQ = 5'b10010;
    localparam logic [4:0] MODE_SVC = 5'b10011;
    localparam logic [4:0] MODE_ABT = 5'b10111;
    localparam logic [4:0] MODE_UND = 5'b11011;
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_irq_sync;
    logic [SYNC_STAGES-1:0] r_fiq_sync;
    logic [2:0]             r_cnt;
    logic                   r_exc_first;
    logic [31:0]            r_pc_wr_val;
    logic [31:0]            r_exc_lr;
    logic [4:0]             r_exc_mode;
    logic                   w_irq_pend;
    logic                   w_fiq_pend;
    logic                   w_req;
    logic                   w_sel_exc;
    logic [31:0]            w_sel_val;
    logic [4:0]             w_sel_mode;
    logic                   w_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_irq_sync <= '0;
            r_fiq_sync <= '0;
        end else begin
            r_irq_sync <= {r_irq_sync[SYNC_STAGES-2:0], i_irq};
            r_fiq_sync <= {r_fiq_sync[SYNC_STAGES-2:0], i_fiq};
        end
    end

    assign w_irq_pend = r_irq_sync[SYNC_STAGES-1] && !i_irq_mask;
    assign w_fiq_pend = r_fiq_sync[SYNC_STAGES-1] && !i_fiq_mask;

    // Fixed priority; a branch only wins when nothing else is active.
    always_comb begin
        w_req      = 1'b1;
        w_sel_exc  = 1'b1;
        w_sel_val  = i_br_target;
        w_sel_mode = r_exc_mode;
        if (i_dabt) begin
            w_sel_val  = 32'h0000_0010;
            w_sel_mode = MODE_ABT;
        end else if (w_fiq_pend) begin
            w_sel_val  = 32'h0000_001C;
            w_sel_mode = MODE_FIQ;
        end else if (w_irq_pend) begin
            w_sel_val  = 32'h0000_0018;
            w_sel_mode = MODE_IRQ;
        end else if (i_pabt) begin
            w_sel_val  = 32'h0000_000C;
            w_sel_mode = MODE_ABT;
        end else if (i_und) begin
            w_sel_val  = 32'h0000_0004;
            w_sel_mode = MODE_UND;
        end else if (i_swi) begin
            w_sel_val  = 32'h0000_0008;
            w_sel_mode = MODE_SVC;
        end else if (i_br_valid) begin
            w_sel_exc = 1'b0;
        end else begin
            w_req     = 1'b0;
            w_sel_exc = 1'b0;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_accept    = 1'b0;
        o_pc_en     = !i_stall;
        o_pc_wr_en  = 1'b0;
        o_flush     = 1'b0;
        o_busy      = 1'b0;
        o_exc_valid = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (!i_stall && w_req) begin
                    w_accept = 1'b1;
                    w_next   = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                o_pc_wr_en  = 1'b1;
                o_flush     = 1'b1;
                o_busy      = 1'b1;
                o_exc_valid = r_exc_first;
                if (!i_stall) w_next = ST_REFILL;
            end
            ST_REFILL: begin
                o_pc_en = 1'b1;
                o_flush = 1'b1;
                o_busy  = 1'b1;
                if (r_cnt == 3'd0) w_next = ST_RUN;
            end
            default: w_next = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_RUN;
            r_cnt       <= 3'd0;
            r_exc_first <= 1'b0;
            r_pc_wr_val <= 32'd0;
            r_exc_lr    <= 32'd0;
            r_exc_mode  <= MODE_SVC;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_pc_wr_val <= w_sel_val;
                r_exc_lr    <= i_pc;
                r_exc_first <= w_sel_exc;
                if (w_sel_exc) r_exc_mode <= w_sel_mode;
            end
            // The entry pulse is consumed by the first REDIRECT cycle, stalled or not.
            if (r_state == ST_REDIRECT) begin
                r_exc_first <= 1'b0;
                if (!i_stall) r_cnt <= CNT_INIT;
            end
            if (r_state == ST_REFILL && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
        end
    end

    assign o_pc_wr_val = r_pc_wr_val;
    assign o_exc_lr    = r_exc_lr;
    assign o_exc_mode  = r_exc_mode;
endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Bench for pc_seq_ctrl: directed and random requests against a cycle-level reference model,
// with redirects scoreboarded and checked by a separate monitor.
module tb_pc_seq_ctrl;
    localparam int FLUSH = 2;
    localparam int SYNC  = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall, i_br_valid, i_dabt, i_pabt, i_und, i_swi;
    logic        i_irq, i_fiq, i_irq_mask, i_fiq_mask;
    logic [31:0] i_br_target;
    logic [31:0] i_pc;
    logic        o_pc_en, o_pc_wr_en, o_flush, o_exc_valid, o_busy;
    logic [31:0] o_pc_wr_val, o_exc_lr;
    logic [4:0]  o_exc_mode;
    logic [31:0] h_pc;

    always #5 clk = ~clk;

    pc_seq_ctrl #(.FLUSH_CYCLES(FLUSH), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .i_stall(i_stall), .i_pc(i_pc),
        .i_br_valid(i_br_valid), .i_br_target(i_br_target),
        .i_dabt(i_dabt), .i_pabt(i_pabt), .i_und(i_und), .i_swi(i_swi),
        .i_irq(i_irq), .i_fiq(i_fiq), .i_irq_mask(i_irq_mask), .i_fiq_mask(i_fiq_mask),
        .o_pc_en(o_pc_en), .o_pc_wr_en(o_pc_wr_en), .o_pc_wr_val(o_pc_wr_val),
        .o_flush(o_flush), .o_exc_valid(o_exc_valid), .o_exc_mode(o_exc_mode),
        .o_exc_lr(o_exc_lr), .o_busy(o_busy)
    );

    // PC register driven by the sequencer outputs
    always @(posedge clk or posedge rst) begin
        if (rst) h_pc <= 32'd0;
        else if (o_pc_en) h_pc <= o_pc_wr_en ? o_pc_wr_val : h_pc + 32'd4;
    end
    assign i_pc = h_pc;

    typedef struct {
        logic [31:0] val;
        logic [4:0]  mode;
        logic [31:0] lr;
        bit          exc;
    } redir_t;

    redir_t sb[$];
    int total = 0;
    int bad   = 0;

    bit          m_redir, m_first;
    int          m_refill;
    logic [31:0] m_pc, m_target;
    logic [4:0]  m_mode;
    bit          irq_hist[$], fiq_hist[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_redir  = 0;
        m_first  = 0;
        m_refill = 0;
        m_pc     = 32'd0;
        m_target = 32'd0;
        m_mode   = 5'b10011;
        irq_hist.delete();
        fiq_hist.delete();
        for (int k = 0; k < SYNC; k++) begin
            irq_hist.push_back(1'b0);
            fiq_hist.push_back(1'b0);
        end
        sb.delete();
    endtask

    task automatic clear_inputs();
        i_stall = 0; i_br_valid = 0; i_br_target = 32'd0;
        i_dabt = 0; i_pabt = 0; i_und = 0; i_swi = 0;
        i_irq = 0; i_fiq = 0; i_irq_mask = 0; i_fiq_mask = 0;
    endtask

    // Called at a falling edge with this cycle's inputs already applied.
    task automatic step();
        bit     irq_s, fiq_s, exp_pc_en, hit;
        redir_t r;
        #1;
        irq_s = irq_hist.pop_front();
        fiq_s = fiq_hist.pop_front();
        irq_hist.push_back(i_irq);
        fiq_hist.push_back(i_fiq);
        exp_pc_en = (m_refill > 0) ? 1'b1 : !i_stall;
        chk("pc", i_pc, m_pc);
        chk("pc_en", o_pc_en, exp_pc_en);
        chk("pc_wr_en", o_pc_wr_en, m_redir);
        chk("flush", o_flush, m_redir || m_refill > 0);
        chk("busy", o_busy, m_redir || m_refill > 0);
        chk("exc_valid", o_exc_valid, m_redir && m_first);
        if (exp_pc_en) m_pc = m_redir ? m_target : m_pc + 32'd4;
        if (m_redir) begin
            m_first = 0;
            if (!i_stall) begin
                m_redir  = 0;
                m_refill = FLUSH;
            end
        end else if (m_refill > 0) begin
            m_refill--;
        end else if (!i_stall) begin
            hit   = 1;
            r.exc = 1;
            r.lr  = m_pc - (exp_pc_en ? 32'd4 : 32'd0);
            if (i_dabt)                       begin r.val = 32'h10; r.mode = 5'b10111; end
            else if (fiq_s && !i_fiq_mask)    begin r.val = 32'h1C; r.mode = 5'b10001; end
            else if (irq_s && !i_irq_mask)    begin r.val = 32'h18; r.mode = 5'b10010; end
            else if (i_pabt)                  begin r.val = 32'h0C; r.mode = 5'b10111; end
            else if (i_und)                   begin r.val = 32'h04; r.mode = 5'b11011; end
            else if (i_swi)                   begin r.val = 32'h08; r.mode = 5'b10011; end
            else if (i_br_valid)              begin r.val = i_br_target; r.mode = m_mode; r.exc = 0; end
            else hit = 0;
            if (hit) begin
                sb.push_back(r);
                m_redir  = 1;
                m_first  = r.exc;
                m_target = r.val;
                if (r.exc) m_mode = r.mode;
            end
        end
        @(negedge clk);
    endtask

    // Asserted at a falling edge; outputs must reach reset values without a clock edge.
    task automatic do_reset();
        rst = 1'b1;
        i_irq = 0;
        i_fiq = 0;
        #1;
        chk("rst_pc_wr_en", o_pc_wr_en, 1'b0);
        chk("rst_pc_wr_val", o_pc_wr_val, 32'd0);
        chk("rst_flush", o_flush, 1'b0);
        chk("rst_exc_valid", o_exc_valid, 1'b0);
        chk("rst_exc_mode", o_exc_mode, 5'b10011);
        chk("rst_exc_lr", o_exc_lr, 32'd0);
        chk("rst_busy", o_busy, 1'b0);
        @(negedge clk);
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Monitor: each new redirect is checked against the oldest expected one.
    initial begin : monitor
        bit     prev;
        redir_t r;
        prev = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                prev = 0;
            end else begin
                if (o_pc_wr_en && !prev) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_redirect actual=%h required=none at %0t", o_pc_wr_val, $time);
                    end else begin
                        r = sb.pop_front();
                        chk("redir_val", o_pc_wr_val, r.val);
                        chk("redir_mode", o_exc_mode, r.mode);
                        chk("redir_is_exc", o_exc_valid, r.exc);
                        if (r.exc) chk("redir_lr", o_exc_lr, r.lr);
                    end
                end
                prev = o_pc_wr_en;
            end
        end
    end

    initial begin
        clear_inputs();
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();
        idle(6);

        i_br_valid = 1; i_br_target = 32'h0000_0100;
        step();
        i_br_valid = 0;
        idle(6);

        // dabt beats an already-synchronised IRQ and a branch in the same cycle
        i_irq_mask = 1; i_irq = 1;
        idle(4);
        i_irq_mask = 0; i_dabt = 1; i_br_valid = 1; i_br_target = 32'h0000_4000;
        step();
        i_dabt = 0; i_br_valid = 0; i_irq = 0;
        idle(10);

        i_irq = 1;
        idle(3);
        i_irq = 0;
        idle(8);
        i_irq_mask = 1; i_irq = 1;
        idle(8);
        i_irq = 0;
        idle(4);
        i_irq_mask = 0;

        i_swi = 1;
        step();
        i_swi = 0; i_stall = 1;
        idle(3);
        i_stall = 0;
        idle(5);

        i_br_valid = 1; i_br_target = 32'hFFFF_FFFC;
        step();
        i_br_valid = 0;
        idle(5);

        i_br_valid = 1; i_br_target = 32'h0000_0200;
        step();
        i_br_valid = 0;
        idle(2);
        do_reset();
        idle(4);

        for (int c = 0; c < 3000; c++) begin
            i_stall     = ($urandom_range(99) < 25);
            i_br_valid  = ($urandom_range(99) < 30);
            i_br_target = {$urandom(), 2'b00} >> 0;
            i_br_target[1:0] = 2'b00;
            i_dabt = ($urandom_range(99) < 4);
            i_pabt = ($urandom_range(99) < 4);
            i_und  = ($urandom_range(99) < 4);
            i_swi  = ($urandom_range(99) < 4);
            if ($urandom_range(99) < 5) i_irq = ~i_irq;
            if ($urandom_range(99) < 5) i_fiq = ~i_fiq;
            if ($urandom_range(99) < 10) i_irq_mask = $urandom_range(1);
            if ($urandom_range(99) < 10) i_fiq_mask = $urandom_range(1);
            if ($urandom_range(999) < 3) do_reset();
            else step();
        end

        clear_inputs();
        idle(20);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
